// File: rtl/wled_pkg.sv
// Shared types and elaboration-time helpers for the WS2812 frame scheduler.
package wled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SEND  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_LATCH = 3'd4
    } wled_state_t;

    localparam int CH_W      = 8;
    localparam int GRB_G_LSB = 16;
    localparam int GRB_R_LSB = 8;
    localparam int GRB_B_LSB = 0;

    function automatic int period_cycles(input int clk_mhz, input int frame_hz);
        return (clk_mhz * 1000000) / frame_hz;
    endfunction

    function automatic int latch_cycles(input int latch_us, input int clk_mhz);
        return latch_us * clk_mhz;
    endfunction

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wled_frame_sched_if.sv
// Word stream from the frame scheduler to the WS2812 serializer.
interface wled_frame_sched_if;
    logic        led_valid;
    logic        led_ready;
    logic [23:0] led_grb;
    logic [7:0]  led_index;

    modport master (output led_valid, output led_grb, output led_index, input led_ready);
    modport slave  (input led_valid, input led_grb, input led_index, output led_ready);
endinterface

// File: rtl/wled_tick_gen.sv
// Refresh-period counter with a one-deep latch for ticks that arrive mid-frame.
module wled_tick_gen
    import wled_pkg::*;
#(
    parameter int PERIOD = 1000
)(
    input  logic clk,
    input  logic rst_n,
    input  logic in_idle,
    input  logic take,
    output logic start
);
    localparam int CW = cnt_width(PERIOD);

    logic [CW-1:0] period_cnt_reg;
    logic          pending_reg;
    logic          tick;

    assign tick  = (period_cnt_reg == CW'(PERIOD - 1));
    assign start = tick | pending_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt_reg <= '0;
            pending_reg    <= 1'b0;
        end else begin
            period_cnt_reg <= tick ? '0 : period_cnt_reg + 1'b1;
            // Ticks seen while idle are either taken or dropped (enable low).
            if (take)
                pending_reg <= 1'b0;
            else if (tick && !in_idle)
                pending_reg <= 1'b1;
        end
    end
endmodule

// File: rtl/wled_frame_sched.sv
// Frame-coherent WS2812 scheduler: snapshot colours once per period, stream
// NUM_LEDS GRB words, wait for the serializer to drain, then hold the latch gap.
module wled_frame_sched
    import wled_pkg::*;
#(
    parameter int CLK_MHZ      = 27,
    parameter int NUM_LEDS     = 8,
    parameter int FRAME_HZ     = 50,
    parameter int LATCH_US     = 80,
    parameter int BLINK_FRAMES = 25
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [7:0]          brightness,
    input  logic [NUM_LEDS-1:0] green,
    input  logic [NUM_LEDS-1:0] red,
    input  logic [NUM_LEDS-1:0] blue,
    input  logic [NUM_LEDS-1:0] blink,
    input  logic                drv_busy,
    output logic                frame_done,
    wled_frame_sched_if.master  led
);
    localparam int PERIOD    = period_cycles(CLK_MHZ, FRAME_HZ);
    localparam int LATCH_CYC = latch_cycles(LATCH_US, CLK_MHZ);
    localparam int IDX_W     = cnt_width(NUM_LEDS);
    localparam int LW        = cnt_width(LATCH_CYC);
    localparam int FW        = cnt_width(BLINK_FRAMES);

    wled_state_t         state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [LW-1:0]       latch_cnt_reg;
    logic [FW-1:0]       frame_cnt_reg;
    logic                phase_reg;
    logic [NUM_LEDS-1:0] snap_green_reg, snap_red_reg, snap_blue_reg, snap_blink_reg;
    logic                start, take, last_word, latch_end;
    logic [23:0]         word_arr [NUM_LEDS];

    assign last_word = (idx_reg == IDX_W'(NUM_LEDS - 1));
    assign latch_end = (latch_cnt_reg == '0);

    wled_tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_idle (state_reg == ST_IDLE),
        .take    (take),
        .start   (start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start && enable)               state_next = ST_LOAD;
            ST_LOAD:                                     state_next = ST_SEND;
            ST_SEND:  if (led.led_ready && last_word)    state_next = ST_DRAIN;
            ST_DRAIN: if (!drv_busy)                     state_next = ST_LATCH;
            ST_LATCH: if (latch_end)                     state_next = ST_IDLE;
            default:                                     state_next = ST_IDLE;
        endcase
    end

    // Colour words come from the snapshot; brightness and blink phase are live.
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_word
        logic        lit;
        logic [23:0] word;
        assign lit = !(snap_blink_reg[gi] && phase_reg);
        always_comb begin
            word = '0;
            word[GRB_G_LSB +: CH_W] = (snap_green_reg[gi] && lit) ? brightness : '0;
            word[GRB_R_LSB +: CH_W] = (snap_red_reg[gi]   && lit) ? brightness : '0;
            word[GRB_B_LSB +: CH_W] = (snap_blue_reg[gi]  && lit) ? brightness : '0;
        end
        assign word_arr[gi] = word;
    end

    always_comb begin
        take           = (state_reg == ST_IDLE) && start && enable;
        led.led_valid  = (state_reg == ST_SEND);
        led.led_grb    = (state_reg == ST_SEND) ? word_arr[idx_reg] : '0;
        led.led_index  = 8'(idx_reg);
        frame_done     = (state_reg == ST_LATCH) && latch_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg        <= '0;
            latch_cnt_reg  <= '0;
            frame_cnt_reg  <= '0;
            phase_reg      <= 1'b0;
            snap_green_reg <= '0;
            snap_red_reg   <= '0;
            snap_blue_reg  <= '0;
            snap_blink_reg <= '0;
        end else begin
            case (state_reg)
                ST_LOAD: begin
                    snap_green_reg <= green;
                    snap_red_reg   <= red;
                    snap_blue_reg  <= blue;
                    snap_blink_reg <= blink;
                    idx_reg        <= '0;
                end
                ST_SEND: if (led.led_ready && !last_word) idx_reg <= idx_reg + 1'b1;
                ST_DRAIN: if (!drv_busy) latch_cnt_reg <= LW'(LATCH_CYC - 1);
                ST_LATCH: begin
                    if (!latch_end) begin
                        latch_cnt_reg <= latch_cnt_reg - 1'b1;
                    end else if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
                        frame_cnt_reg <= '0;
                        phase_reg     <= ~phase_reg;
                    end else begin
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
